// File: rtl/calc_port_driver.sv
// Drives one calculator port: it serialises a host operation into the two-cycle request
// protocol and returns the port response. Optional timeout guarded by CALC_DRV_TIMEOUT_EN.
module calc_port_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_op1,
  input  logic [31:0] cmd_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp_in,
  input  logic [31:0] out_data_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic [7:0]  stray_cnt
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StOp1  = 3'd1;
  localparam logic [2:0] StOp2  = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StHold = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic [31:0] op2_q, op2_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0]  stray_q, stray_d;

`ifdef CALC_DRV_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;
`else
  logic unused_tmo_param;
  assign unused_tmo_param = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    req_cmd_d   = req_cmd_q;
    req_data_d  = req_data_q;
    op2_d       = op2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_data_d  = rsp_data_q;
    stray_d     = stray_q;
`ifdef CALC_DRV_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    // Responses outside WAIT never reach the host; they are only counted.
    if ((out_resp_in != 2'd0) && (state_q != StWait) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op2_d = cmd_op2;
          if (cmd_op != 4'd0) begin
            req_cmd_d  = cmd_op;
            req_data_d = cmd_op1;
            state_d    = StOp1;
          end else begin
            // Op 0 is answered locally as invalid without touching the port.
            rsp_resp_d  = 2'd3;
            rsp_data_d  = 32'd0;
            rsp_valid_d = 1'b1;
`ifdef CALC_DRV_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
            state_d = StHold;
          end
        end
      end
      StOp1: begin
        req_cmd_d  = 4'd0;
        req_data_d = op2_q;
        state_d    = StOp2;
      end
      StOp2: begin
        req_data_d = 32'd0;
`ifdef CALC_DRV_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (out_resp_in != 2'd0) begin
          rsp_resp_d  = out_resp_in;
          rsp_data_d  = out_data_in;
          rsp_valid_d = 1'b1;
`ifdef CALC_DRV_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = StHold;
        end
`ifdef CALC_DRV_TIMEOUT_EN
        else if (tmo_cnt_q == TmoLast) begin
          rsp_resp_d    = 2'd0;
          rsp_data_d    = 32'd0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = StHold;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      StHold: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      req_cmd_q   <= 4'd0;
      req_data_q  <= 32'd0;
      op2_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= 2'd0;
      rsp_data_q  <= 32'd0;
      stray_q     <= 8'd0;
`ifdef CALC_DRV_TIMEOUT_EN
      tmo_cnt_q     <= 8'd0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      op2_q       <= op2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_data_q  <= rsp_data_d;
      stray_q     <= stray_d;
`ifdef CALC_DRV_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_data     = rsp_data_q;
  assign stray_cnt    = stray_q;
`ifdef CALC_DRV_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_calc_port_driver.sv
// Bench for calc_port_driver: the bench plays the calculator port and the host.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_calc_port_driver;

  localparam int Tmo   = 4;
  localparam int Never = 1000;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_op1;
  logic [31:0] cmd_op2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp_in;
  logic [31:0] out_data_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [7:0]  stray_cnt;

  calc_port_driver #(.TIMEOUT_CYCLES(Tmo)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_op1     (cmd_op1),
    .cmd_op2     (cmd_op2),
    .req_cmd_out (req_cmd_out),
    .req_data_out(req_data_out),
    .out_resp_in (out_resp_in),
    .out_data_in (out_data_in),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_resp    (rsp_resp),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .stray_cnt   (stray_cnt)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          dly;   // WAIT cycle (0-based) on which the port answers
    logic [1:0]  resp;
    logic [31:0] data;
    logic        tmo;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int exp_stray = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  // Behaviour of the calculator port as seen by the driver.
  function automatic void calc_model(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [1:0] resp,
                                     output logic [31:0] data);
    logic [32:0] sum;
    case (op)
      4'd1: begin sum = {1'b0, a} + {1'b0, b}; data = sum[31:0]; resp = sum[32] ? 2'd2 : 2'd1; end
      4'd2: begin data = a - b; resp = (b > a) ? 2'd2 : 2'd1; end
      4'd5: begin data = a << b[4:0]; resp = 2'd1; end
      4'd6: begin data = a >> b[4:0]; resp = 2'd1; end
      default: begin data = 32'd0; resp = 2'd3; end
    endcase
  endfunction

  function automatic int exp_waits(input int dly);
`ifdef CALC_DRV_TIMEOUT_EN
    if (dly >= Tmo) return Tmo;
`endif
    return dly + 1;
  endfunction

  function automatic void bump_stray();
    if (exp_stray < 255) exp_stray++;
  endfunction

  task automatic do_op(input vec_t v, input int hold, input string nm);
    logic [1:0]  mresp;
    logic [31:0] mdata;
    int          waits;
    bit          stable;
    calc_model(v.op, v.a, v.b, mresp, mdata);
    chk({nm, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_op1 = v.a; cmd_op2 = v.b;
    @(negedge c_clk);
    // Keep offering junk commands; they must be ignored until IDLE.
    cmd_op = 4'd2; cmd_op1 = $urandom; cmd_op2 = $urandom;
    chk({nm, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
    if (v.op != 4'd0) begin
      chk({nm, ".req_cyc1"}, {req_cmd_out, req_data_out[27:0]}, {v.op, v.a[27:0]});
      chk({nm, ".req_data1"}, req_data_out, v.a);
      @(negedge c_clk);
      chk({nm, ".req_cmd2"}, 32'(req_cmd_out), 32'd0);
      chk({nm, ".req_data2"}, req_data_out, v.b);
      @(negedge c_clk);
      chk({nm, ".req_idle"}, req_data_out | 32'(req_cmd_out), 32'd0);
      waits = 0;
      while (!rsp_valid && waits < 300) begin
        if (waits == v.dly) begin out_resp_in = mresp; out_data_in = mdata; end
        @(negedge c_clk);
        out_resp_in = 2'd0; out_data_in = $urandom;
        waits++;
      end
      chk({nm, ".wait_cycles"}, 32'(waits), 32'(exp_waits(v.dly)));
    end else begin
      chk({nm, ".local_no_req"}, 32'(req_cmd_out), 32'd0);
    end
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, ".rsp_resp"}, 32'(rsp_resp), 32'(v.resp));
    chk({nm, ".rsp_data"}, rsp_data, v.data);
    chk({nm, ".rsp_timeout"}, 32'(rsp_timeout), 32'(v.tmo));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin out_resp_in = 2'd1; out_data_in = 32'hDEAD_BEEF; bump_stray(); end
      @(negedge c_clk);
      out_resp_in = 2'd0;
      if (rsp_valid !== 1'b1 || rsp_resp !== v.resp || rsp_data !== v.data ||
          rsp_timeout !== v.tmo || cmd_ready !== 1'b0 || req_cmd_out !== 4'd0) stable = 1'b0;
    end
    if (hold > 0) begin
      chk({nm, ".hold_stable"}, 32'(stable), 32'd1);
      chk({nm, ".stray_hold"}, 32'(stray_cnt), 32'(exp_stray));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    chk({nm, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".cmd_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t v;
    int   sel;
    logic [1:0]  mr;
    logic [31:0] md;
    bit   quiet;

    tbl[0] = '{4'd1, 32'd5,         32'd3,   0, 2'd1, 32'd8,         1'b0};
    tbl[1] = '{4'd1, 32'hFFFF_FFFF, 32'd1,   1, 2'd2, 32'd0,         1'b0};
    tbl[2] = '{4'd0, 32'd12,        32'd34,  0, 2'd3, 32'd0,         1'b0};
    tbl[3] = '{4'd2, 32'd3,         32'd5,   2, 2'd2, 32'hFFFF_FFFE, 1'b0};
    tbl[4] = '{4'd5, 32'd1,         32'd4,   0, 2'd1, 32'd16,        1'b0};
    tbl[5] = '{4'd6, 32'h80,        32'd3,   3, 2'd1, 32'h10,        1'b0};
    tbl[6] = '{4'd9, 32'd7,         32'd7,   1, 2'd3, 32'd0,         1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_op1 = '0; cmd_op2 = '0;
    out_resp_in = '0; out_data_in = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge c_clk);
    reset = 1'b0;
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset.req", req_data_out | 32'(req_cmd_out), 32'd0);
    chk("reset.rsp", {29'd0, rsp_valid, rsp_resp} | rsp_data | 32'(rsp_timeout), 32'd0);
    chk("reset.stray", 32'(stray_cnt), 32'd0);

    for (int i = 0; i < 7; i++) do_op(tbl[i], i % 3, $sformatf("tbl%0d", i));

    // Backpressure: hold the result for 10 cycles with a stray response inside.
    do_op(tbl[0], 10, "backpressure");

`ifdef CALC_DRV_TIMEOUT_EN
    v = '{4'd1, 32'd2, 32'd2, Never, 2'd0, 32'd0, 1'b1};
    do_op(v, 0, "timeout");
    v = '{4'd1, 32'd2, 32'd2, Tmo - 1, 2'd1, 32'd4, 1'b0};
    do_op(v, 0, "resp_last_wait");
`endif

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: v.op = 4'd0;
        1: v.op = 4'd1;
        2: v.op = 4'd2;
        3: v.op = 4'd5;
        4: v.op = 4'd6;
        default: v.op = 4'($urandom_range(7, 15));
      endcase
      v.a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      v.b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      v.dly = $urandom_range(0, Tmo - 1);
`ifdef CALC_DRV_TIMEOUT_EN
      if ($urandom_range(0, 4) == 0) v.dly = Never;
`endif
      v.tmo = 1'b0;
      if (v.op == 4'd0) begin
        v.resp = 2'd3; v.data = 32'd0;
      end else if (v.dly >= Tmo) begin
        v.resp = 2'd0; v.data = 32'd0; v.tmo = 1'b1;
      end else begin
        calc_model(v.op, v.a, v.b, mr, md);
        v.resp = mr; v.data = md;
      end
      do_op(v, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    // Stray counter saturation while idle.
    for (int i = 0; i < 260; i++) begin
      out_resp_in = 2'($urandom_range(1, 3));
      bump_stray();
      @(negedge c_clk);
    end
    out_resp_in = 2'd0;
    chk("stray.saturate", 32'(stray_cnt), 32'(exp_stray));
    chk("stray.no_rsp", 32'(rsp_valid), 32'd0);

    // Reset while in OP1 aborts the operation.
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_op1 = 32'd9; cmd_op2 = 32'd9;
    @(negedge c_clk);
    cmd_valid = 1'b0;
    chk("abort.in_op1", 32'(req_cmd_out), 32'd1);
    reset = 1'b1;
    @(negedge c_clk);
    reset = 1'b0;
    exp_stray = 0;
    chk("abort.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort.req", req_data_out | 32'(req_cmd_out), 32'd0);
    chk("abort.rsp", {29'd0, rsp_valid, rsp_resp} | rsp_data | 32'(rsp_timeout), 32'd0);
    chk("abort.stray", 32'(stray_cnt), 32'd0);
    quiet = 1'b1;
    repeat (Tmo + 6) begin
      @(negedge c_clk);
      if (rsp_valid !== 1'b0 || req_cmd_out !== 4'd0 || cmd_ready !== 1'b1) quiet = 1'b0;
    end
    chk("abort.quiet", 32'(quiet), 32'd1);
    do_op(tbl[4], 1, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
